// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and address-field width helpers for the
//                set-associative data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    // Byte offset bits inside one line
    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Set index bits
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: whatever is left above index and offset
    function automatic int tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - offset_w(line_w) - index_w(sets);
    endfunction

    // Word-select bits inside one line
    function automatic int wsel_w(input int line_w, input int data_w);
        return $clog2(line_w / data_w);
    endfunction

    // Way number / age width; a direct-mapped cache still needs one bit
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_lru.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_lru
//  Description : Per-set age-based LRU tracking with victim selection.
//                Ages form a permutation of 0..WAYS-1 inside each set.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 2,
    localparam int IDX_W = index_w(SETS),
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] query_set,
    input  logic [WAYS-1:0]  query_valid,
    output logic [WAY_W-1:0] victim,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way
);

    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic [WAY_W-1:0] w_old_age;
    logic [WAY_W-1:0] w_max_age;
    logic             w_found;

    assign w_old_age = r_age[upd_set][upd_way];

    // Victim: first invalid way, otherwise the oldest way of the set
    always_comb begin
        w_found   = 1'b0;
        victim    = '0;
        w_max_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!query_valid[w] && !w_found) begin
                victim  = WAY_W'(w);
                w_found = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[query_set][w] >= w_max_age) begin
                    w_max_age = r_age[query_set][w];
                    victim    = WAY_W'(w);
                end
            end
        end
    end

    // Age update: accessed way becomes youngest, younger ways age by one
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == upd_way) begin
                    r_age[upd_set][w] <= '0;
                end else if (r_age[upd_set][w] < w_old_age) begin
                    r_age[upd_set][w] <= r_age[upd_set][w] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_assoc
//  Description : N-way set-associative write-back / write-allocate data
//                cache with LRU replacement and a single line-wide memory
//                port. Misses stall the pipeline until the line is resident.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i
);

    localparam int OFF_W  = offset_w(LINE_W);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WSEL_W = wsel_w(LINE_W, DATA_W);
    localparam int IDX_W  = index_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int WAY_W  = way_w(WAYS);

    // Storage arrays
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];

    // Miss context, captured when leaving IDLE so a dropped request still
    // completes against the right set and way
    state_e            r_state, w_state_nxt;
    logic [WAY_W-1:0]  r_victim;
    logic [TAG_W-1:0]  r_miss_tag;
    logic [IDX_W-1:0]  r_miss_idx;

    logic [TAG_W-1:0]  w_req_tag;
    logic [IDX_W-1:0]  w_req_idx;
    logic [WSEL_W-1:0] w_req_wsel;
    logic              w_unused_bits;
    logic              w_req, w_serve, w_miss;
    logic [WAYS-1:0]   w_hit_vec;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_hit;
    logic [LINE_W-1:0] w_hit_line;
    logic              w_rd_hit, w_wr_hit, w_refill_done;
    logic [WAY_W-1:0]  w_lru_victim;
    logic              w_victim_dirty;
    logic              w_lru_upd;
    logic [IDX_W-1:0]  w_lru_set;
    logic [WAY_W-1:0]  w_lru_way;

    assign w_req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign w_req_wsel    = p1_addr_i[BYTE_W +: WSEL_W];
    assign w_unused_bits = ^p1_addr_i[BYTE_W-1:0];

    assign w_req   = p1_MemRead_i | p1_MemWrite_i;
    assign w_serve = (r_state == ST_IDLE) || (r_state == ST_DONE);

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag);
            if (w_hit_vec[w]) begin
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit          = |w_hit_vec;
    assign w_hit_line     = r_data[w_req_idx][w_hit_way];
    assign w_miss         = (r_state == ST_IDLE) && w_req && !w_hit;
    // A simultaneous read+write is a store, so it never returns data
    assign w_rd_hit       = w_serve && p1_MemRead_i && !p1_MemWrite_i && w_hit;
    assign w_wr_hit       = w_serve && p1_MemWrite_i && w_hit;
    assign w_refill_done  = (r_state == ST_REFILL) && mem_ack_i;
    assign w_victim_dirty = r_valid[w_req_idx][w_lru_victim] && r_dirty[w_req_idx][w_lru_victim];

    assign p1_data_o  = w_rd_hit ? w_hit_line[w_req_wsel*DATA_W +: DATA_W] : '0;
    assign p1_stall_o = (r_state == ST_WRITEBACK) || (r_state == ST_REFILL) || w_miss;

    // LRU is touched on any serviced hit and when a refill lands
    assign w_lru_upd = w_refill_done || (w_serve && w_req && w_hit);
    assign w_lru_set = w_refill_done ? r_miss_idx : w_req_idx;
    assign w_lru_way = w_refill_done ? r_victim : w_hit_way;

    dcache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .query_set   (w_req_idx),
        .query_valid (r_valid[w_req_idx]),
        .victim      (w_lru_victim),
        .upd_en      (w_lru_upd),
        .upd_set     (w_lru_set),
        .upd_way     (w_lru_way)
    );

    // State register and miss-context capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_victim   <= '0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_victim   <= w_lru_victim;
                r_miss_tag <= w_req_tag;
                r_miss_idx <= w_req_idx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_miss) w_state_nxt = w_victim_dirty ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK: if (mem_ack_i) w_state_nxt = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory port drive; quiet outside the two transfer states
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[r_miss_idx][r_victim], r_miss_idx, {OFF_W{1'b0}}};
                mem_data_o   = r_data[r_miss_idx][r_victim];
            end
            ST_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {r_miss_tag, r_miss_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Valid/dirty flags: set on refill, dirtied by stores
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_refill_done) begin
            r_valid[r_miss_idx][r_victim] <= 1'b1;
            r_dirty[r_miss_idx][r_victim] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_req_idx][w_hit_way] <= 1'b1;
        end
    end

    // Tag/data arrays; gated by valid, so they need no reset
    always_ff @(posedge clk_i) begin
        if (w_refill_done) begin
            r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
            r_data[r_miss_idx][r_victim] <= mem_data_i;
        end else if (w_wr_hit) begin
            r_data[w_req_idx][w_hit_way][w_req_wsel*DATA_W +: DATA_W] <= p1_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_assoc
//  Description : Directed self-checking bench for dcache_assoc. One instance
//                with default geometry, one with SETS=2 / WAYS=4; each is
//                held in reset while the other is exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_assoc;

    logic         clk = 1'b0;
    logic         rst0, rst4, sel;
    logic [31:0]  addr, wdata;
    logic         rd, wr, ack;
    logic [255:0] mem_rdata;

    logic [31:0]  data0, data4, maddr0, maddr4;
    logic [255:0] mdat0, mdat4;
    logic         stall0, stall4, men0, men4, mwr0, mwr4;

    logic [31:0]  data_o, mem_addr;
    logic [255:0] mem_wdata;
    logic         stall, mem_en, mem_wr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign data_o    = sel ? data4  : data0;
    assign stall     = sel ? stall4 : stall0;
    assign mem_en    = sel ? men4   : men0;
    assign mem_wr    = sel ? mwr4   : mwr0;
    assign mem_addr  = sel ? maddr4 : maddr0;
    assign mem_wdata = sel ? mdat4  : mdat0;

    dcache_assoc u_dut0 (
        .clk_i (clk), .rst_i (rst0),
        .p1_addr_i (addr), .p1_data_i (wdata),
        .p1_MemRead_i (rd), .p1_MemWrite_i (wr),
        .p1_data_o (data0), .p1_stall_o (stall0),
        .mem_addr_o (maddr0), .mem_data_o (mdat0), .mem_data_i (mem_rdata),
        .mem_enable_o (men0), .mem_write_o (mwr0), .mem_ack_i (ack & ~sel)
    );

    dcache_assoc #(.SETS(2), .WAYS(4)) u_dut4 (
        .clk_i (clk), .rst_i (rst4),
        .p1_addr_i (addr), .p1_data_i (wdata),
        .p1_MemRead_i (rd), .p1_MemWrite_i (wr),
        .p1_data_o (data4), .p1_stall_o (stall4),
        .mem_addr_o (maddr4), .mem_data_o (mdat4), .mem_data_i (mem_rdata),
        .mem_enable_o (men4), .mem_write_o (mwr4), .mem_ack_i (ack & sel)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = {a[31:5], 5'b0};
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 + base + 32'(k * 4);
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input logic [31:0] a);
        return l[a[4:2]*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as memory for one transfer; ack is high in the lat-th cycle
    task automatic mem_xfer(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                            input logic [255:0] exp_wline, input logic [255:0] rline, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_en && n < 16);
        if (!mem_en) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
            return;
        end
        check({tag, "_wr"}, mem_wr, exp_wr);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_stall"}, stall, 1'b1);
        if (exp_wr) check({tag, "_wline"}, mem_wdata, exp_wline);
        repeat (lat - 1) @(negedge clk);
        mem_rdata = rline;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic read_miss(input string tag, input logic [31:0] a, input int lat);
        tick(); rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        check({tag, "_miss_stall"}, stall, 1'b1);
        mem_xfer(tag, 1'b0, {a[31:5], 5'b0}, '0, mk_line(a), lat);
        @(negedge clk);
        check({tag, "_done_stall"}, stall, 1'b0);
        check({tag, "_done_data"}, data_o, word_of(mk_line(a), a));
    endtask

    task automatic write_miss(input string tag, input logic [31:0] a, input logic [31:0] d, input int lat);
        tick(); rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check({tag, "_miss_stall"}, stall, 1'b1);
        mem_xfer(tag, 1'b0, {a[31:5], 5'b0}, '0, mk_line(a), lat);
        @(negedge clk);
        check({tag, "_done_stall"}, stall, 1'b0);
        check({tag, "_done_data"}, data_o, 32'h0);
    endtask

    task automatic read_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        tick(); rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_data"}, data_o, exp);
    endtask

    task automatic probe_miss(input string tag, input logic [31:0] a);
        tick(); rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        check({tag, "_stall"}, stall, 1'b1);
        check({tag, "_men"}, mem_en, 1'b0);
        rd = 1'b0;
    endtask

    logic [255:0] line_a, merged;

    initial begin
        rst0 = 1'b0; rst4 = 1'b0; sel = 1'b0;
        rd = 1'b0; wr = 1'b0; ack = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0;
        line_a = '0;
        for (int k = 1; k < 8; k++) line_a[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        line_a[31:0] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_men", mem_en, 1'b0);
        check("rst_mwr", mem_wr, 1'b0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_mdata", mem_wdata, 256'h0);
        check("rst_data", data_o, 32'h0);
        tick(); rst0 = 1'b1;

        // Clean miss on 0x100, ack in the third REFILL cycle
        tick(); rd = 1'b1; addr = 32'h100;
        @(negedge clk);
        check("m1_idle_stall", stall, 1'b1);
        check("m1_idle_men", mem_en, 1'b0);
        tick(); @(negedge clk);
        check("m1_r1_men", mem_en, 1'b1);
        check("m1_r1_mwr", mem_wr, 1'b0);
        check("m1_r1_addr", mem_addr, 32'h100);
        check("m1_r1_stall", stall, 1'b1);
        tick(); @(negedge clk);
        check("m1_r2_stall", stall, 1'b1);
        tick(); ack = 1'b1; mem_rdata = line_a;
        @(negedge clk);
        check("m1_r3_stall", stall, 1'b1);
        tick(); ack = 1'b0;
        @(negedge clk);
        check("m1_done_stall", stall, 1'b0);
        check("m1_done_data", data_o, 32'hDEAD_BEEF);
        check("m1_done_men", mem_en, 1'b0);
        read_hit("m1_rehit", 32'h100, 32'hDEAD_BEEF);

        // Store hit then read back
        tick(); rd = 1'b0; wr = 1'b1; addr = 32'h104; wdata = 32'h1122_3344;
        @(negedge clk);
        check("wh_stall", stall, 1'b0);
        check("wh_data", data_o, 32'h0);
        read_hit("wh_rd104", 32'h104, 32'h1122_3344);
        read_hit("wh_rd100", 32'h100, 32'hDEAD_BEEF);

        // Fill set 0 with 0x000 and dirty 0x200, touch 0x000, then evict via 0x400
        read_miss("f0", 32'h000, 2);
        write_miss("f2", 32'h208, 32'hCAFE_F00D, 1);
        read_hit("t0", 32'h000, 32'hA000_0000);
        merged = mk_line(32'h200);
        merged[2*32 +: 32] = 32'hCAFE_F00D;
        tick(); rd = 1'b1; wr = 1'b0; addr = 32'h400;
        @(negedge clk);
        check("ev_idle_stall", stall, 1'b1);
        mem_xfer("ev_wb", 1'b1, 32'h200, merged, '0, 1);
        mem_xfer("ev_rf", 1'b0, 32'h400, '0, mk_line(32'h400), 2);
        @(negedge clk);
        check("ev_done_stall", stall, 1'b0);
        check("ev_done_data", data_o, 32'hA000_0400);
        read_hit("ev_keep0", 32'h000, 32'hA000_0000);
        probe_miss("ev_gone200", 32'h200);
        read_hit("ev_other_set", 32'h104, 32'h1122_3344);

        // Reset in the middle of REFILL
        tick(); rd = 1'b1; addr = 32'h600;
        @(negedge clk);
        check("ra_idle_stall", stall, 1'b1);
        @(negedge clk);
        check("ra_pre_men", mem_en, 1'b1);
        rst0 = 1'b0; ack = 1'b1; mem_rdata = '1;
        #1;
        check("ra_men", mem_en, 1'b0);
        check("ra_mwr", mem_wr, 1'b0);
        check("ra_maddr", mem_addr, 32'h0);
        tick(); ack = 1'b0; rd = 1'b0;
        tick(); tick(); rst0 = 1'b1;
        probe_miss("ra_600", 32'h600);
        probe_miss("ra_100", 32'h100);

        // Four-way geometry: LRU replacement
        tick(); rst0 = 1'b0; sel = 1'b1;
        tick(); rst4 = 1'b1;
        read_miss("w4_t0", 32'h000, 1);
        read_miss("w4_t1", 32'h040, 3);
        read_miss("w4_t2", 32'h080, 1);
        read_miss("w4_t3", 32'h0C0, 2);
        read_hit("w4_reuse0", 32'h000, 32'hA000_0000);
        read_miss("w4_t4", 32'h100, 1);
        probe_miss("w4_t1_gone", 32'h040);
        read_hit("w4_t0_kept", 32'h000, 32'hA000_0000);
        read_hit("w4_t2_kept", 32'h084, 32'hA000_0084);
        read_hit("w4_t3_kept", 32'h0C4, 32'hA000_00C4);
        read_hit("w4_t4_res", 32'h11C, 32'hA000_011C);

        tick(); rd = 1'b0; wr = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
